// File: rtl/tiny1_uart_pkg.sv
// tiny1_uart_pkg: shared state types and sizing
// helpers for the tiny1 8N1 UART.
package tiny1_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_st_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_st_t;

  localparam int BITS_PER_FRAME = 10;

  function automatic int cnt_w(input int clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/tiny1_uart_fifo.sv
// tiny1_uart_fifo: small synchronous RX FIFO with
// combinational head and a registered overrun pulse.
module tiny1_uart_fifo
  import tiny1_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_overrun;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_pop     = i_pop && !o_empty;
  // a pop in the same cycle frees the slot a full push needs
  assign w_push    = i_push && (!w_full || w_pop);
  assign o_head    = r_mem[r_rp];
  assign o_overrun = r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_push && w_full && !w_pop;
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tiny1_uart.sv
// tiny1_uart: 8N1 transceiver for the tiny1 CPU with
// a 2-flop RX synchronizer and a small RX FIFO.
module tiny1_uart
  import tiny1_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic       busy,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  // the detect cycle in IDLE counts toward the half bit
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 2);

  tx_st_t        r_tx_st;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_buf;
  logic          r_tx;
  logic          r_busy;
  logic          w_tx_tick;

  rx_st_t        r_rx_st;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic [1:0]    r_sync;
  logic          r_fe;
  logic          w_rx_s;
  logic          w_rx_tick;
  logic          w_push;
  logic          w_empty;

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign frame_err = r_fe;
  assign valid     = !w_empty;
  assign w_tx_tick = (r_tx_cnt == C_LAST);
  assign w_rx_tick = (r_rx_cnt == C_LAST);
  assign w_rx_s    = r_sync[1];
  assign w_push    = (r_rx_st == RX_STOP) && w_rx_tick && w_rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_buf <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_tx_st)
        TX_IDLE: begin
          r_tx_cnt <= '0;
          if (wr) begin
            r_tx_buf <= tx_data;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_tx_st  <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx     <= r_tx_buf[0];
            r_tx_st  <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_tx_st <= TX_STOP;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx     <= r_tx_buf[r_tx_bit + 3'd1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            r_busy   <= 1'b0;
            r_tx_st  <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_fe     <= 1'b0;
    end else begin
      r_fe <= 1'b0;
      unique case (r_rx_st)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (!w_rx_s) begin
            r_rx_st <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == C_HALF) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_st  <= w_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {w_rx_s, r_rx_sh[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_st <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // leave mid-stop so the next start edge is not missed
          if (w_rx_tick) begin
            r_rx_cnt <= '0;
            r_fe     <= !w_rx_s;
            r_rx_st  <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  tiny1_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (r_rx_sh),
    .i_pop     (rd),
    .o_head    (rx_data),
    .o_empty   (w_empty),
    .o_overrun (overrun)
  );

endmodule

// File: tb/tb_tiny1_uart.sv
// tb_tiny1_uart: scoreboard bench for tiny1_uart
// at CLKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_tiny1_uart;

  localparam int CPB = 8;

  logic       clk;
  logic       rst;
  logic       rx_drv;
  logic       lb;
  logic       w_rx;
  logic       tx;
  logic       wr;
  logic [7:0] tx_data;
  logic       busy;
  logic       rd;
  logic [7:0] rx_data;
  logic       valid;
  logic       overrun;
  logic       frame_err;

  int n_vec;
  int n_err;
  int n_ovr;
  int n_fe;
  int exp_ovr;
  int exp_fe;
  logic [7:0] exp_q [$];

  assign w_rx = lb ? tx : rx_drv;

  tiny1_uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (w_rx),
    .tx        (tx),
    .wr        (wr),
    .tx_data   (tx_data),
    .busy      (busy),
    .rd        (rd),
    .rx_data   (rx_data),
    .valid     (valid),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun === 1'b1) n_ovr++;
    if (frame_err === 1'b1) n_fe++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    if (bad) begin
      rx_drv = 1'b0;
      repeat (CPB * 3 / 4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (CPB / 4) @(negedge clk);
      exp_fe++;
    end else begin
      rx_drv = 1'b1;
      repeat (CPB) @(negedge clk);
      if (exp_q.size() < 4) exp_q.push_back(b);
      else exp_ovr++;
    end
  endtask

  task automatic pop_chk(input string tag);
    int t;
    logic [7:0] e;
    t = 0;
    while (!valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, valid, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    chk(tag, rx_data, e);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit poke);
    logic [9:0] f;
    int nb;
    f  = {1'b1, b, 1'b0};
    nb = 0;
    tx_data = b;
    wr = 1'b1;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      wr = 1'b0;
      if (poke && k == 40) begin
        wr = 1'b1;
        tx_data = ~b;
      end
      if (k % CPB == CPB / 2) chk("tx_bit", tx, f[k / CPB]);
      if (busy) nb++;
    end
    @(negedge clk);
    wr = 1'b0;
    chk("busy_len", nb, 10 * CPB);
    chk("busy_end", busy, 0);
    chk("tx_idle", tx, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("tx_done", busy, 0);
  endtask

  initial begin
    int lat;
    n_vec = 0; n_err = 0; n_ovr = 0; n_fe = 0;
    exp_ovr = 0; exp_fe = 0;
    rst = 1'b1; rx_drv = 1'b1; lb = 1'b0;
    wr = 1'b0; rd = 1'b0; tx_data = '0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rxdata", rx_data, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_fe", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tx_frame(8'hA5, 1'b1);

    fork
      send_byte(8'h3C, 1'b0);
      begin
        lat = 0;
        while (!valid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("rx_lat", (lat >= 75 && lat <= 78), 1);
    pop_chk("rx_3c");
    chk("rx_empty", valid, 0);

    for (int i = 1; i <= 5; i++) send_byte(i[7:0], 1'b0);
    repeat (4) @(negedge clk);
    chk("ovr_cnt", n_ovr, exp_ovr);
    fork
      send_byte(8'h06, 1'b0);
      begin
        repeat (75) @(negedge clk);
        chk("full_head", rx_data, exp_q.pop_front());
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("ovr_fullpop", n_ovr, exp_ovr);
    for (int i = 0; i < 4; i++) pop_chk("ovr_pop");
    chk("ovr_empty", valid, 0);

    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", valid, 0);
    chk("glitch_fe", n_fe, exp_fe);
    send_byte(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    chk("fe_cnt", n_fe, exp_fe);
    chk("fe_valid", valid, 0);
    send_byte(8'h66, 1'b0);
    pop_chk("after_fe");

    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("pre_rst_valid", valid, 1);
    tx_data = 8'h5A;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tx_frame(8'h81, 1'b0);

    lb = 1'b1;
    tx_data = 8'h00;
    wr = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk);
    wr = 1'b0;
    wait_idle();
    tx_data = 8'hFF;
    wr = 1'b1;
    exp_q.push_back(8'hFF);
    @(negedge clk);
    wr = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    pop_chk("lb_00");
    pop_chk("lb_ff");
    chk("lb_fe", n_fe, exp_fe);
    chk("lb_ovr", n_ovr, exp_ovr);
    chk("lb_empty", valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tiny1_uart.md
Name: tiny1_uart

Overview:
8N1 UART transceiver with a small RX FIFO.
- Sits directly downstream of the tiny1 CPU's memory-mapped UART ports: consumes `wr`/`tx_data`, produces `valid`/`rx_data`, and pops on `rd`.
- Drives the board `tx` pin directly.
- Receives the pin `rx` through an internal 2-flop synchronizer.
- Adds buffering and error flags so the CPU's polling loop tolerates back-to-back bytes.

Parameters:
CLKS_PER_BIT, 104, clock cycles per bit period (12 MHz / 115200); must be >= 4.
FIFO_DEPTH, 4, RX FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset. Single clock domain, clk only.
rx  in  1  serial input from pin, asynchronous to clk; idles high.
tx  out  1  serial output to pin, registered; idles high.
wr  in  1  one-cycle strobe: start transmitting tx_data.
tx_data  in  8  byte to transmit, sampled when wr is accepted.
busy  out  1  transmitter occupied; wr is ignored while high.
rd  in  1  one-cycle strobe: pop the FIFO head.
rx_data  out  8  FIFO head byte; valid only when valid=1.
valid  out  1  FIFO non-empty.
overrun  out  1  one-cycle pulse: a received byte was dropped because the FIFO was full.
frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.

Behaviour:
Reset (async, immediate):
- tx=1, busy=0, valid=0, rx_data=0, overrun=0, frame_err=0.
- Both FSMs go to IDLE, FIFO pointers are cleared, synchronizer flops are set to 1.
- A reset mid-frame aborts the frame; tx returns high without waiting for a clock.

TX FSM (IDLE, START, DATA, STOP):
- wr in IDLE captures tx_data; the next edge sets busy=1, tx=0, state START.
- Each state holds for CLKS_PER_BIT cycles.
- DATA shifts out 8 bits LSB first, using a 3-bit index.
- STOP drives tx=1; at its end busy=0 and the FSM returns to IDLE.
- busy is high for exactly 10*CLKS_PER_BIT cycles per frame.
- wr while busy=1 is ignored; no queuing.
- wr in the same cycle busy falls is ignored; wr on the following cycle is accepted.

RX path:
- rx passes through 2 flops to give rx_s.

RX FSM (IDLE, START, DATA, STOP):
- IDLE: rx_s=0 -> START, counter cleared.
- START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
  - rx_s=1 is a glitch -> IDLE, nothing reported.
  - rx_s=0 -> DATA.
- DATA: sample every CLKS_PER_BIT cycles (bit centres), LSB first, into an 8-bit shift register; after 8 samples -> STOP.
- STOP: sample after CLKS_PER_BIT cycles, then return to IDLE immediately (the mid-stop return permits back-to-back frames).
  - rx_s=1: push the byte.
  - rx_s=0: pulse frame_err, no push.

RX FIFO:
- Storage is mem[FIFO_DEPTH]. Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. A count is log2(FIFO_DEPTH)+1 bits.
- valid = (count != 0).
- rx_data = mem[rd_ptr], registered storage and combinational output.
- rd with valid=1 pops; the new head and valid are visible the next cycle.
- rd with valid=0 is ignored.
- Push when full with no pop: byte dropped, overrun pulses, contents unchanged.
- Push and pop in the same cycle when full: both succeed, no overrun, count unchanged.
- Push and pop in the same cycle when empty: the pop is ignored and the push succeeds (count=1).

TX and RX are fully independent; simultaneous activity is allowed.

Decomposition:
- Package tiny1_uart_pkg holds:
  - the TX/RX state enums (2-bit);
  - BITS_PER_FRAME=10;
  - the function computing the counter width, clog2(CLKS_PER_BIT).
- One sub-module, tiny1_uart_fifo: synchronous FIFO with push/pop/full/empty/head and the overrun pulse.
- TX, RX FSMs and the synchronizer stay in tiny1_uart.

Test Plan:
All scenarios use CLKS_PER_BIT=8, FIFO_DEPTH=4.
1. TX: wr with tx_data=0xA5 from idle -> tx=0 for 8 cycles, then bits 1,0,1,0,0,1,0,1 (8 cycles each), then 1; busy high exactly 80 cycles. A second wr at cycle 40 is ignored.
2. RX: drive the frame for 0x3C on rx -> valid rises 75-78 cycles after the start edge with rx_data=0x3C; rd -> valid=0 next cycle.
3. Overrun: 5 back-to-back frames 0x01..0x05, no rd -> one overrun pulse at the 5th stop sample; popping yields 0x01,0x02,0x03,0x04 then valid=0. Full+push+rd same cycle -> no overrun.
4. Glitch/framing: rx low for 3 cycles -> no valid, no pulses. Frame 0x55 with stop bit low -> frame_err pulse, valid stays 0, next good frame 0x66 received.
5. Reset: assert rst mid-TX at cycle 30 and with 2 bytes in the FIFO -> tx=1, busy=0, valid=0 immediately. After release, wr 0x81 transmits a clean full frame.
6. Loopback tx->rx, wr 0x00 and 0xFF consecutively -> both received in order, no errors.
